// File: rtl/address_ram_map_pkg.sv
// Shared address-map tables for the weight/bias loader: per-layer window lengths
// and the constant functions that place them back to back in external RAM.
package addr_map_pkg;

    localparam int STEP_W     = 7;
    localparam int ADDR_W     = 18;
    localparam int NUM_LAYERS = 29;
    localparam int K_W        = $clog2(NUM_LAYERS);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        PH_WEIGHT  = 2'd0,
        PH_BIAS    = 2'd1,
        PH_COMPUTE = 2'd2,
        PH_IDLE    = 2'd3
    } phase_e;

    // Word counts per layer; the final layer is dense and has no bias window.
    localparam int unsigned W_LEN [0:NUM_LAYERS-1] = '{
        432,   144,   256,   144,   512,   288,   1024,  288,   2048,  576,
        4096,  576,   4096,  576,   4096,  576,   4096,  576,   4096,  576,
        4096,  576,   8192,  1152,  16384, 1152,  16384, 2304,  10240
    };

    localparam int unsigned B_LEN [0:NUM_LAYERS-2] = '{
        16,  16,  16,  32,  32,  32,  64,  32,  64,  64,
        128, 64,  128, 64,  128, 64,  128, 64,  128, 64,
        128, 64,  256, 128, 256, 128, 256, 128
    };

    function automatic int unsigned wbase(input int unsigned k);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < k; i++) begin
            sum += W_LEN[i] + B_LEN[i];
        end
        return sum;
    endfunction

    function automatic int unsigned bbase(input int unsigned k);
        return wbase(k) + W_LEN[k];
    endfunction

    function automatic int unsigned total_words();
        return wbase(NUM_LAYERS - 1) + W_LEN[NUM_LAYERS - 1];
    endfunction

endpackage

// File: rtl/address_ram_map_if.sv
// Step-in / window-out bundle between the loader sequencer and the address map.
interface address_ram_map_if;
    import addr_map_pkg::*;

    logic [STEP_W-1:0] step;
    logic              re_weights;
    logic              re_bias;
    addr_t             firstaddr;
    addr_t             lastaddr;

    modport master (
        output step,
        input  re_weights,
        input  re_bias,
        input  firstaddr,
        input  lastaddr
    );

    modport slave (
        input  step,
        output re_weights,
        output re_bias,
        output firstaddr,
        output lastaddr
    );

endinterface

// File: rtl/address_ram_map.sv
// Decodes the 1-based loader step into a registered RAM window and read enables.
// All window bounds are elaboration-time constants; the only runtime logic is muxing.
module address_ram_map
    import addr_map_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    address_ram_map_if.slave       bus
);

    localparam int NUM_STEPS = 2 ** STEP_W;

    // Refuse to build a map that overflows the address space or has empty windows.
    if (total_words() > (32'd1 << ADDR_W)) begin : g_err_total
        $error("address_ram_map: packed layout exceeds 2**ADDR_W words");
    end

    genvar gi;

    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_chk_w
        if (W_LEN[gi] < 1) begin : g_err
            $error("address_ram_map: zero-length weight window");
        end
    end

    for (gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_chk_b
        if (B_LEN[gi] < 1) begin : g_err
            $error("address_ram_map: zero-length bias window");
        end
    end

    // Step -> (phase, layer) lookup; out-of-range layers collapse to idle here.
    phase_e         ph_lut [NUM_STEPS];
    logic [K_W-1:0] k_lut  [NUM_STEPS];

    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_lut
        localparam int K = (gi == 0) ? 0 : (gi - 1) / 3;
        localparam int R = (gi == 0) ? 3 : (gi - 1) % 3;
        localparam bit W_OK = (R == 0) && (K < NUM_LAYERS);
        localparam bit B_OK = (R == 1) && (K < NUM_LAYERS - 1);
        assign ph_lut[gi] = W_OK ? PH_WEIGHT :
                            B_OK ? PH_BIAS :
                            (R == 2) ? PH_COMPUTE : PH_IDLE;
        assign k_lut[gi]  = (W_OK || B_OK) ? K_W'(K) : '0;
    end

    addr_t w_first [NUM_LAYERS];
    addr_t w_last  [NUM_LAYERS];
    addr_t b_first [NUM_LAYERS-1];
    addr_t b_last  [NUM_LAYERS-1];

    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_wwin
        assign w_first[gi] = ADDR_W'(wbase(gi));
        assign w_last[gi]  = ADDR_W'(wbase(gi) + W_LEN[gi] - 1);
    end

    for (gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_bwin
        assign b_first[gi] = ADDR_W'(bbase(gi));
        assign b_last[gi]  = ADDR_W'(bbase(gi) + B_LEN[gi] - 1);
    end

    phase_e         phase;
    logic [K_W-1:0] layer;

    logic  re_weights_d, re_weights_q;
    logic  re_bias_d,    re_bias_q;
    addr_t firstaddr_d,  firstaddr_q;
    addr_t lastaddr_d,   lastaddr_q;

    always_comb begin
        phase        = ph_lut[bus.step];
        layer        = k_lut[bus.step];
        re_weights_d = 1'b0;
        re_bias_d    = 1'b0;
        firstaddr_d  = '0;
        lastaddr_d   = '0;
        case (phase)
            PH_WEIGHT: begin
                re_weights_d = 1'b1;
                firstaddr_d  = w_first[layer];
                lastaddr_d   = w_last[layer];
            end
            PH_BIAS: begin
                re_bias_d   = 1'b1;
                firstaddr_d = b_first[layer];
                lastaddr_d  = b_last[layer];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_weights_q <= 1'b0;
            re_bias_q    <= 1'b0;
            firstaddr_q  <= '0;
            lastaddr_q   <= '0;
        end else begin
            re_weights_q <= re_weights_d;
            re_bias_q    <= re_bias_d;
            firstaddr_q  <= firstaddr_d;
            lastaddr_q   <= lastaddr_d;
        end
    end

    assign bus.re_weights = re_weights_q;
    assign bus.re_bias    = re_bias_q;
    assign bus.firstaddr  = firstaddr_q;
    assign bus.lastaddr   = lastaddr_q;

endmodule

// File: tb/tb_address_ram_map.sv
// Self-checking bench for address_ram_map: directed cases, a full step sweep,
// randomized steps with sporadic reset, and a long hold on the last window.
module tb_address_ram_map;
    import addr_map_pkg::*;

    logic clk;
    logic rst;

    address_ram_map_if bus();

    address_ram_map dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference map: one entry per step value, built by walking the packed layout.
    bit          m_we    [128];
    bit          m_be    [128];
    int unsigned m_first [128];
    int unsigned m_last  [128];
    int unsigned m_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_model();
        int unsigned addr;
        for (int s = 0; s < 128; s++) begin
            m_we[s] = 0; m_be[s] = 0; m_first[s] = 0; m_last[s] = 0;
        end
        addr = 0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            m_we[3*l+1]    = 1;
            m_first[3*l+1] = addr;
            m_last[3*l+1]  = addr + W_LEN[l] - 1;
            addr += W_LEN[l];
            if (l < NUM_LAYERS - 1) begin
                m_be[3*l+2]    = 1;
                m_first[3*l+2] = addr;
                m_last[3*l+2]  = addr + B_LEN[l] - 1;
                addr += B_LEN[l];
            end
        end
        m_total = addr;
    endtask

    // Drive one step (and reset level) and sample just after the capturing edge.
    task automatic apply(input int s, input bit r);
        @(negedge clk);
        bus.step = 7'(s);
        rst      = r;
        @(posedge clk);
        #1;
        $display("step=%0d rst=%0d -> we=%0d be=%0d first=%0d last=%0d",
                 s, r, bus.re_weights, bus.re_bias, bus.firstaddr, bus.lastaddr);
    endtask

    task automatic check_outputs(input string tag, input bit we, input bit be,
                                 input int unsigned first, input int unsigned last);
        check({tag, ".we"},    32'(bus.re_weights), 32'(we));
        check({tag, ".be"},    32'(bus.re_bias),    32'(be));
        check({tag, ".first"}, 32'(bus.firstaddr),  first);
        check({tag, ".last"},  32'(bus.lastaddr),   last);
    endtask

    task automatic check_model(input string tag, input int s);
        check_outputs(tag, m_we[s], m_be[s], m_first[s], m_last[s]);
        check({tag, ".excl"}, 32'(bus.re_weights & bus.re_bias), 32'd0);
    endtask

    initial begin
        int n_w, n_b;
        int unsigned next_addr;
        int s;
        bit r;

        n_cmp = 0;
        n_bad = 0;
        build_model();
        bus.step = '0;
        rst      = 1'b1;

        // Reset held two cycles with step=1, then released.
        apply(1, 1);
        apply(1, 1);
        check_outputs("reset", 0, 0, 0, 0);
        apply(1, 0);
        check_outputs("step1", 1, 0, 0, 431);

        apply(2, 0);
        check_outputs("step2", 0, 1, 432, 447);
        apply(4, 0);
        check_outputs("step4", 1, 0, 448, 591);
        apply(5, 0);
        check_outputs("step5", 0, 1, 592, 607);
        apply(3, 0);
        check_outputs("step3", 0, 0, 0, 0);
        apply(6, 0);
        check_outputs("step6", 0, 0, 0, 0);

        // Full sweep: model match plus structural properties of the layout.
        n_w = 0;
        n_b = 0;
        next_addr = 0;
        for (int i = 0; i < 128; i++) begin
            apply(i, 0);
            check_model("sweep", i);
            if (bus.re_weights || bus.re_bias) begin
                check("sweep.contig", 32'(bus.firstaddr), next_addr);
                next_addr = 32'(bus.lastaddr) + 1;
            end
            if (bus.re_weights) n_w++;
            if (bus.re_bias)    n_b++;
            if (i == 85) begin
                check("step85.we",   32'(bus.re_weights), 32'd1);
                check("step85.last", 32'(bus.lastaddr), m_total - 1);
            end
            if (i == 86) check_outputs("step86", 0, 0, 0, 0);
        end
        check("sweep.n_weight", 32'(n_w), 32'd29);
        check("sweep.n_bias",   32'(n_b), 32'd28);
        check("sweep.total",    next_addr, m_total);

        // Reset asserted on the same edge the step moves 1 -> 2.
        apply(1, 0);
        apply(2, 1);
        check_outputs("rst_prio", 0, 0, 0, 0);
        apply(2, 0);
        check_outputs("rst_release", 0, 1, 432, 447);

        // Random steps with occasional reset.
        for (int i = 0; i < 300; i++) begin
            s = int'($urandom_range(0, 127));
            r = ($urandom_range(0, 15) == 0);
            apply(s, r);
            if (r) check_outputs("rand.rst", 0, 0, 0, 0);
            else   check_model("rand", s);
        end

        // Long hold on the final dense-layer window.
        for (int i = 0; i < 100; i++) begin
            apply(85, 0);
            check_model("hold85", 85);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
